// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared constants for the RV32M multiply/divide unit
package rv_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_CALC = 2'd1;
    localparam logic [1:0] MDU_FIX  = 2'd2;
    localparam logic [1:0] MDU_DONE = 2'd3;

endpackage

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: one shift-add (multiply) or restoring shift-subtract (divide) step
module rv_muldiv_iter
    import rv_muldiv_pkg::*;
(
    input  logic                  is_div,
    input  logic [2*XLEN-1:0]     acc,
    input  logic [XLEN-1:0]       m,
    output logic [2*XLEN-1:0]     acc_nxt
);

    logic [XLEN:0] sum, rem_sh, diff;

    // multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, quotient/dividend}
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = rem_sh - {1'b0, m};
        acc_nxt = is_div ? (diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                       : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                         : {sum, acc[XLEN-1:1]};
    end

endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit (32 iterations + sign fix)
module rv_muldiv_unit #(
    parameter int XLEN = rv_muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import rv_muldiv_pkg::*;

    if (XLEN != 32) begin : g_xlen_chk
        $error("rv_muldiv_unit supports only XLEN == 32");
    end

    logic [1:0]      state;
    logic [2:0]      f3;
    logic [4:0]      cnt;
    logic [63:0]     acc, acc_nxt, prod;
    logic [31:0]     m, a_mag, b_mag, q_fix, r_fix, res_sel, spec_res;
    logic            sa, sb, a_sgn, b_sgn, div0, ovf;

    rv_muldiv_iter u_iter (
        .is_div  (f3[2]),
        .acc     (acc),
        .m       (m),
        .acc_nxt (acc_nxt)
    );

    assign busy = state != MDU_IDLE;
    assign done = state == MDU_DONE;

    // operand magnitudes, special-case detection and final sign correction/selection
    always_comb begin
        a_sgn    = op_a[31] && (funct3 == MDU_MULH || funct3 == MDU_MULHSU || funct3 == MDU_DIV || funct3 == MDU_REM);
        b_sgn    = op_b[31] && (funct3 == MDU_MULH || funct3 == MDU_DIV || funct3 == MDU_REM);
        a_mag    = a_sgn ? -op_a : op_a;
        b_mag    = b_sgn ? -op_b : op_b;
        div0     = funct3[2] && op_b == '0;
        ovf      = (funct3 == MDU_DIV || funct3 == MDU_REM) && op_a == 32'h8000_0000 && op_b == '1;
        spec_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : 32'h8000_0000);
        prod     = (sa ^ sb) ? -acc : acc;
        q_fix    = (sa ^ sb) ? -acc[31:0] : acc[31:0];
        r_fix    = sa ? -acc[63:32] : acc[63:32];
        res_sel  = f3 == MDU_MUL ? prod[31:0] : !f3[2] ? prod[63:32] : f3[1] ? r_fix : q_fix;
    end

    // control FSM, iteration counter, datapath registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MDU_IDLE;
            f3     <= '0;
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                MDU_IDLE: if (start) begin
                    f3  <= funct3;
                    sa  <= a_sgn;
                    sb  <= b_sgn;
                    cnt <= 5'd31;
                    m   <= funct3[2] ? b_mag : a_mag;
                    acc <= {32'b0, funct3[2] ? a_mag : b_mag};
                    if (div0 || ovf) begin
                        result <= spec_res;
                        state  <= MDU_DONE;
                    end else begin
                        state  <= MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 5'd1;
                    if (cnt == '0) state <= MDU_FIX;
                end
                MDU_FIX: begin
                    result <= res_sel;
                    state  <= MDU_DONE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed self-checking bench for rv_muldiv_unit
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;
    int          tests = 0;
    int          fails = 0;

    rv_muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one op; poke=1 re-asserts start with other operands during CALC
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit poke);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        n = 1;
        busy_cnt = 0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            if (poke && n == 5) begin
                start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (busy) busy_cnt++;
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy"}, 64'(busy_cnt), 64'(lat));
        check({tag, "_res"}, {32'b0, result}, {32'b0, exp});
        @(posedge clk); #1;
        check({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        #12;
        check("rst_state", {30'b0, busy, done, result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 1'b0);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b0);
        run_op("divu",    3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 34, 1'b0);
        run_op("remu",    3'd7, 32'hFFFF_FFF9,  32'd2,         32'd1,         34, 1'b0);
        run_op("rem_pn",  3'd6, 32'd100,        32'hFFFF_FFF9, 32'd2,         34, 1'b0);
        run_op("divu_big",3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34, 1'b0);
        run_op("div0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("remu0",   3'd7, 32'd5,          32'd0,         32'd5,         1,  1'b0);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1'b0);
        run_op("mul_poke",3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("hold_res", {32'b0, result}, 64'hFFFF_FFEB);
        check("hold_done", {63'b0, done}, 64'd0);

        begin
            int dones;
            @(negedge clk);
            start = 1'b1; funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("arst", {30'b0, busy, done, result}, 64'd0);
            #1;
            rst_n = 1'b1;
            dones = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            check("arst_nodone", 64'(dones), 64'd0);
        end

        run_op("post_rst", 3'd4, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
